// File: rtl/featuremap_pad_writer.sv
// Wraps a raster-order feature map with a one-pixel zero border and streams the
// padded frame into a channel FIFO, one word per cycle when not stalled.
module featuremap_pad_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 112,
    parameter int HEIGHT     = 112
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready_in,
    input  logic                  fifo_full,
    output logic                  wrreq,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam int RW = $clog2(HEIGHT + 2);

    localparam logic [CW-1:0] COL_PAD_LAST  = CW'(WIDTH + 1);
    localparam logic [CW-1:0] COL_DATA_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(HEIGHT - 1);

    typedef enum logic [2:0] {
        IDLE,
        TOP,
        LEFT,
        DATA,
        RIGHT,
        BOTTOM,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           col_q, col_d;
    logic [RW-1:0]           row_q, row_d;
    logic                    wrreq_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    done_q;
    logic                    emit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Every transition is gated by emit, so a FIFO stall or upstream gap freezes position.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = TOP;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            TOP: begin
                if (emit) begin
                    if (col_q == COL_PAD_LAST) begin
                        state_d = LEFT;
                        col_d   = '0;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            LEFT: begin
                if (emit) begin
                    state_d = DATA;
                    col_d   = '0;
                end
            end
            DATA: begin
                if (emit) begin
                    if (col_q == COL_DATA_LAST) begin
                        state_d = RIGHT;
                        col_d   = '0;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            RIGHT: begin
                if (emit) begin
                    if (row_q == ROW_LAST) begin
                        state_d = BOTTOM;
                        row_d   = '0;
                    end else begin
                        state_d = LEFT;
                        row_d   = row_q + RW'(1);
                    end
                end
            end
            BOTTOM: begin
                if (emit) begin
                    if (col_q == COL_PAD_LAST) begin
                        state_d = DONE;
                        col_d   = '0;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                col_d   = '0;
                row_d   = '0;
            end
        endcase
    end

    always_comb begin
        ready_in = (state_q == DATA) && !fifo_full;
        busy     = (state_q != IDLE);
        emit     = 1'b0;
        unique case (state_q)
            TOP, LEFT, RIGHT, BOTTOM: emit = !fifo_full;
            DATA:                     emit = valid_in && !fifo_full;
            default:                  emit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrreq_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            wrreq_q <= emit;
            done_q  <= (state_q == DONE);
            if (emit) begin
                data_q <= (state_q == DATA) ? data_in : '0;
            end
        end
    end

    assign wrreq      = wrreq_q;
    assign data_out   = data_q;
    assign frame_done = done_q;

endmodule

// File: doc/featuremap_pad_writer.md
FEATUREMAP_PAD_WRITER -- requirements
Module: featuremap_pad_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: pixel word width (IEEE-754 single).
REQ-002 SHALL have parameter WIDTH, default 112: unpadded feature-map columns.
REQ-003 SHALL have parameter HEIGHT, default 112: unpadded feature-map rows.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins one padded frame.
REQ-007 SHALL have port valid_in  input  1  upstream pixel valid.
REQ-008 SHALL have port data_in  input  DATA_WIDTH  upstream pixel, raster order.
REQ-009 SHALL have port ready_in  output  1  pixel accepted this cycle when valid_in && ready_in.
REQ-010 SHALL have port fifo_full  input  1  channel FIFO almost-full; asserts with at least one free entry remaining.
REQ-011 SHALL have port wrreq  output  1  registered FIFO write strobe.
REQ-012 SHALL have port data_out  output  DATA_WIDTH  registered FIFO write data.
REQ-013 SHALL have port busy  output  1  frame in progress.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after the last padded word is written.

Function
REQ-015 SHALL emit exactly (WIDTH+2)*(HEIGHT+2) words per frame, in raster order, for the downstream conv2D window of width WIDTH+2.
REQ-016 SHALL write 32'h0000_0000 for row 0, row HEIGHT+1, column 0 and column WIDTH+1; interior positions SHALL carry upstream pixels unchanged.
REQ-017 SHALL use states IDLE, TOP, LEFT, DATA, RIGHT, BOTTOM, DONE.
REQ-018 IDLE->TOP on start; start outside IDLE SHALL be ignored.
REQ-019 TOP emits WIDTH+2 zeros, then LEFT.
REQ-020 LEFT emits one zero, then DATA.
REQ-021 DATA emits WIDTH accepted pixels, then RIGHT.
REQ-022 RIGHT emits one zero, then LEFT when rows remain, else BOTTOM after the HEIGHT-th row.
REQ-023 BOTTOM emits WIDTH+2 zeros, then DONE; DONE lasts one cycle, pulses frame_done, returns to IDLE.
REQ-024 A word is emitted in a cycle only when fifo_full is 0; if fifo_full is 1, state, counters and position SHALL hold and wrreq SHALL be 0 on the next edge.
REQ-025 ready_in SHALL be combinational: (state==DATA) && !fifo_full; it SHALL be 0 in every other state.
REQ-026 In DATA, a word is emitted only on valid_in && ready_in; a valid_in gap SHALL produce wrreq 0 with no state advance.
REQ-027 wrreq and data_out SHALL register on the edge ending the emitting cycle, giving a latency of 1 cycle from acceptance to write.
REQ-028 data_out SHALL hold its last value when wrreq is 0.
REQ-029 A column counter of width clog2(WIDTH+2) and a row counter of width clog2(HEIGHT+2) SHALL clear at each state/row boundary and never exceed WIDTH+1 or HEIGHT-1 respectively.
REQ-030 busy SHALL be 1 in all states except IDLE.
REQ-031 Throughput SHALL be one word per cycle with fifo_full low and valid_in high continuously.
REQ-032 Frame length SHALL be WIDTH*HEIGHT + 2*WIDTH + 2*HEIGHT + 4 cycles plus stall cycles, plus one DONE cycle.
REQ-033 start coinciding with DONE SHALL be ignored; a new frame requires start in IDLE.

Reset
REQ-034 rst low SHALL immediately force IDLE, counters 0, wrreq 0, data_out 0, busy 0, frame_done 0, ready_in 0, regardless of clk.
REQ-035 Reset mid-frame SHALL abandon the frame without further writes.
REQ-036 After rst rises, the block SHALL wait for start.

Verification
REQ-037 WIDTH=4, HEIGHT=4, start, valid_in always 1, fifo_full 0, pixels 1..16 -> 36 writes; rows 0 and 5 all zero; row r (1..4) = 0, 4r-3..4r, 0; frame_done at the cycle after the 36th write.
REQ-038 Same setup, fifo_full held high 3 cycles during the TOP word 2 -> exactly 3 extra cycles, no duplicated or lost zero, 36 writes total.
REQ-039 valid_in low for 2 cycles mid-row -> ready_in stays high, wrreq 0 for those 2 cycles, pixel order intact.
REQ-040 rst pulsed low during row 2 -> wrreq 0 asynchronously, busy 0; next start yields a clean full 36-word frame.
REQ-041 start pulsed while busy, and start on the DONE cycle -> both ignored; word count unchanged.
REQ-042 Defaults WIDTH=112, HEIGHT=112 with random fifo_full and valid_in -> 12996 writes, border words zero, interior equal to the input sequence.
